// File: rtl/fault_code_display.sv
`default_nettype none
// ============================================================================
// Module   : fault_code_display
// Purpose  : Drives a two-digit 7-segment LED display through a 595-style
//            shift register. It shows the faulted VR index in hex, or "--"
//            when no fault is active. On a 250 ms refresh request it captures
//            the fault code, builds a 16-bit active-low segment frame, and
//            shifts the frame out MSB first. It then pulses the storage latch.
// Ports    : iClk          - system clock, rising edge
//            iRst          - synchronous active-high reset
//            i250mSCE      - one-cycle refresh strobe
//            iFaultCode    - faulted VR index (shown as two hex digits)
//            iFaultPresent - at least one fault active
//            iFaultStage   - power stage of the fault, 15 = multiple faults
//            oSerData      - serial data, MSB first
//            oSerClk       - serial shift clock
//            oSerLatch     - storage-register latch strobe
//            oBusy         - frame in flight
//            oDisplayCode  - code captured for the current/last frame
// Params   : CLK_DIV       - serial half-period in iClk cycles (1..255)
// Macros   : FAULT_BLINK_EN - when defined, faulted frames alternate with a
//            blank frame on successive refreshes (2 Hz blink)
// Revision : 1.0 - initial release
// ============================================================================
module fault_code_display #(
    parameter int CLK_DIV = 4
) (
    input  logic       iClk,
    input  logic       iRst,
    input  logic       i250mSCE,
    input  logic [7:0] iFaultCode,
    input  logic       iFaultPresent,
    input  logic [3:0] iFaultStage,
    output logic       oSerData,
    output logic       oSerClk,
    output logic       oSerLatch,
    output logic       oBusy,
    output logic [7:0] oDisplayCode
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] SHIFT = 2'd2;
    localparam logic [1:0] LATCH = 2'd3;

    localparam logic [7:0]  DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [4:0]  HALF_LAST  = 5'd31;
    localparam logic [15:0] FRAME_DASH = 16'hBFBF;
`ifdef FAULT_BLINK_EN
    localparam logic [15:0] FRAME_BLANK = 16'hFFFF;
`endif

    logic [1:0]  state;
    logic        pending;
    logic [4:0]  half_cnt;      // serial half-period index, 0..31 within SHIFT
    logic [7:0]  div_cnt;       // iClk cycles within the current half-period
    logic [15:0] shreg;
    logic [7:0]  display_code;
    logic [15:0] frame_next;
    logic [7:0]  seg_hi;
    logic [7:0]  seg_lo;
`ifdef FAULT_BLINK_EN
    logic        blink_phase;
`endif

    // Hex digit to {dp,g,f,e,d,c,b,a}, active-low, dp off.
    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            default: seg = 8'h8E;
        endcase
        return seg;
    endfunction

    // Frame built from the live inputs; only sampled in LOAD.
    always_comb begin
        seg_hi = hex_to_seg(iFaultCode[7:4]);
        seg_lo = hex_to_seg(iFaultCode[3:0]);
        // Lit decimal point on the high digit flags "multiple faults".
        if (iFaultPresent && (iFaultStage == 4'hF)) begin
            seg_hi[7] = 1'b0;
        end
        frame_next = {seg_hi, seg_lo};
        if (!iFaultPresent) begin
            frame_next = FRAME_DASH;
        end
`ifdef FAULT_BLINK_EN
        else if (blink_phase) begin
            frame_next = FRAME_BLANK;
        end
`endif
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state        <= IDLE;
            pending      <= 1'b0;
            half_cnt     <= 5'd0;
            div_cnt      <= 8'd0;
            shreg        <= 16'd0;
            display_code <= 8'h00;
`ifdef FAULT_BLINK_EN
            blink_phase  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    half_cnt <= 5'd0;
                    div_cnt  <= 8'd0;
                    if (i250mSCE || pending) begin
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    display_code <= iFaultCode;
                    shreg        <= frame_next;
                    pending      <= 1'b0;
`ifdef FAULT_BLINK_EN
                    blink_phase  <= ~blink_phase;
`endif
                    state        <= SHIFT;
                end
                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= 8'd0;
                        // Advance the data as the clock falls (end of a high
                        // half), so it is stable for the whole high half.
                        if (half_cnt[0]) begin
                            shreg <= {shreg[14:0], 1'b0};
                        end
                        if (half_cnt == HALF_LAST) begin
                            half_cnt <= 5'd0;
                            state    <= LATCH;
                        end else begin
                            half_cnt <= half_cnt + 5'd1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                LATCH: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt <= 8'd0;
                        state   <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase

            // A strobe while busy (including the final LATCH cycle and LOAD)
            // leaves exactly one request waiting; this takes priority over
            // the clear in LOAD.
            if (i250mSCE && (state != IDLE)) begin
                pending <= 1'b1;
            end
        end
    end

    assign oBusy        = (state != IDLE);
    assign oSerClk      = (state == SHIFT) && half_cnt[0];
    assign oSerData     = (state == SHIFT) && shreg[15];
    assign oSerLatch    = (state == LATCH);
    assign oDisplayCode = display_code;

endmodule
`default_nettype wire

// File: tb/tb_fault_code_display.sv
`default_nettype none
// ============================================================================
// Module   : tb_fault_code_display
// Purpose  : Self-checking bench for fault_code_display (CLK_DIV = 2).
//            A negedge monitor decodes the serial stream into frames, latch
//            widths and busy lengths. The stimulus block compares these
//            against a segment-table reference model.
//            With FAULT_BLINK_EN defined, the model also applies the blink.
// Revision : 1.0 - initial release
// ============================================================================
module tb_fault_code_display;

    localparam int CLK_DIV   = 2;
    localparam int FRAME_LEN = 1 + 33 * CLK_DIV;
`ifdef FAULT_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sce = 1'b0;
    logic [7:0] code = 8'h00;
    logic       present = 1'b0;
    logic [3:0] stage = 4'h0;
    logic       ser_data, ser_clk, ser_latch, busy;
    logic [7:0] disp;

    fault_code_display #(.CLK_DIV(CLK_DIV)) dut (
        .iClk         (clk),
        .iRst         (rst),
        .i250mSCE     (sce),
        .iFaultCode   (code),
        .iFaultPresent(present),
        .iFaultStage  (stage),
        .oSerData     (ser_data),
        .oSerClk      (ser_clk),
        .oSerLatch    (ser_latch),
        .oBusy        (busy),
        .oDisplayCode (disp)
    );

    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic [7:0] seg_tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                 8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    logic phase = 1'b0;

    // ---------------- monitor ----------------
    logic [15:0] frame_q [$];
    int          lat_q   [$];
    int          blen_q  [$];
    int          rise_q  [$];
    int          fall_q  [$];
    logic [15:0] acc = 16'd0;
    int          lat = 0;
    int          bcnt = 0;
    int          cyc = 0;
    int          viol = 0;
    logic        p_busy = 1'b0, p_clk = 1'b0, p_data = 1'b0, p_latch = 1'b0;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (busy && !p_busy) begin
            rise_q.push_back(cyc);
            bcnt <= 1;
            lat  <= 0;
            acc  <= 16'd0;
        end else begin
            if (busy) bcnt <= bcnt + 1;
            if (ser_latch) lat <= lat + 1;
            if (ser_clk && !p_clk) acc <= {acc[14:0], ser_data};
        end
        if (!busy && p_busy) begin
            fall_q.push_back(cyc);
            blen_q.push_back(bcnt);
        end
        if (ser_clk && p_clk && (ser_data !== p_data)) viol <= viol + 1;
        if (!ser_latch && p_latch) begin
            frame_q.push_back(acc);
            lat_q.push_back(lat);
        end
        p_busy  <= busy;
        p_clk   <= ser_clk;
        p_data  <= ser_data;
        p_latch <= ser_latch;
    end

    // ---------------- reference model ----------------
    function automatic logic [15:0] model(input logic [7:0] c, input logic p,
                                          input logic [3:0] s, input logic ph);
        logic [7:0] hi;
        logic [7:0] lo;
        hi = seg_tbl[c[7:4]];
        lo = seg_tbl[c[3:0]];
        if (!p) return 16'hBFBF;
        if (BLINK && ph) return 16'hFFFF;
        if (s == 4'd15) hi = hi - 8'h80;   // all table entries have dp set
        return {hi, lo};
    endfunction

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clear_mon();
        frame_q.delete();
        lat_q.delete();
        blen_q.delete();
        rise_q.delete();
        fall_q.delete();
    endtask

    task automatic pulse_after(input int n);
        repeat (n) @(posedge clk);
        #1 sce = 1'b1;
        @(posedge clk);
        #1 sce = 1'b0;
    endtask

    task automatic wait_frames(input string tag, input int n);
        int i;
        for (i = 0; i < 3000; i++) begin
            @(negedge clk);
            #1;
            if (frame_q.size() >= n && blen_q.size() >= n && !busy) break;
        end
        check({tag, "_timeout"}, 32'(i < 3000), 32'd1);
    endtask

    task automatic check_frame(input string tag, input int idx);
        logic [15:0] exp;
        exp   = model(code, present, stage, phase);
        phase = ~phase;
        if (frame_q.size() > idx && lat_q.size() > idx && blen_q.size() > idx) begin
            check({tag, "_frame"}, 32'(frame_q[idx]), 32'(exp));
            check({tag, "_latch_len"}, 32'(lat_q[idx]), 32'(CLK_DIV));
            check({tag, "_busy_len"}, 32'(blen_q[idx]), 32'(FRAME_LEN));
        end else begin
            check({tag, "_missing"}, 32'(frame_q.size()), 32'(idx + 1));
        end
    endtask

    task automatic run_frame(input string tag, input logic [7:0] c,
                             input logic p, input logic [3:0] s);
        code = c; present = p; stage = s;
        clear_mon();
        pulse_after(1);
        wait_frames(tag, 1);
        check_frame(tag, 0);
        check({tag, "_disp"}, 32'(disp), 32'(c));
        check({tag, "_clk_high_stable"}, 32'(viol), 32'd0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_data",  32'(ser_data),  32'd0);
        check("rst_clk",   32'(ser_clk),   32'd0);
        check("rst_latch", 32'(ser_latch), 32'd0);
        check("rst_busy",  32'(busy),      32'd0);
        check("rst_disp",  32'(disp),      32'd0);
        rst = 1'b0;
        repeat (3) @(posedge clk);

        // Directed frames
        run_frame("code_1A", 8'h1A, 1'b1, 4'd3);
        run_frame("multi_05", 8'h05, 1'b1, 4'd15);
        run_frame("nofault", 8'h7E, 1'b0, 4'd15);

        // Three strobes during one frame -> exactly one extra frame
        code = 8'h3C; present = 1'b1; stage = 4'd2;
        clear_mon();
        pulse_after(1);
        pulse_after(5);
        pulse_after(20);
        pulse_after(30);
        wait_frames("burst", 2);
        repeat (200) @(negedge clk);
        #1;
        check("burst_frame_count", 32'(frame_q.size()), 32'd2);
        check_frame("burst0", 0);
        check_frame("burst1", 1);
        if (rise_q.size() > 1 && fall_q.size() > 0)
            check("burst_restart", 32'(rise_q[1]), 32'(fall_q[0] + 1));
        else
            check("burst_restart_missing", 32'(rise_q.size()), 32'd2);

        // Strobe on the final LATCH cycle -> exactly one further frame
        code = 8'hD2; present = 1'b1; stage = 4'd15;
        clear_mon();
        pulse_after(1);
        pulse_after(33 * CLK_DIV);
        wait_frames("edge", 2);
        repeat (200) @(negedge clk);
        #1;
        check("edge_frame_count", 32'(frame_q.size()), 32'd2);
        check_frame("edge0", 0);
        check_frame("edge1", 1);

        // Reset mid-SHIFT aborts the frame without a latch pulse
        code = 8'h99; present = 1'b1; stage = 4'd1;
        clear_mon();
        pulse_after(1);
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        check("abort_data",  32'(ser_data),  32'd0);
        check("abort_clk",   32'(ser_clk),   32'd0);
        check("abort_latch", 32'(ser_latch), 32'd0);
        check("abort_busy",  32'(busy),      32'd0);
        check("abort_disp",  32'(disp),      32'd0);
        rst   = 1'b0;
        phase = 1'b0;
        repeat (150) @(negedge clk);
        #1;
        check("abort_no_frame", 32'(frame_q.size()), 32'd0);
        run_frame("after_abort", 8'h99, 1'b1, 4'd1);

        // Randomized frames
        for (int k = 0; k < 8; k++) begin
            logic [3:0] s;
            s = (($urandom_range(0, 2)) == 0) ? 4'd15 : 4'($urandom_range(0, 15));
            run_frame($sformatf("rand%0d", k), 8'($urandom_range(0, 255)),
                      1'($urandom_range(0, 3) != 0), s);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fault_code_display.md
FAULT_CODE_DISPLAY -- requirements
Module: fault_code_display

Interface
REQ-001 Parameter CLK_DIV, default 4: serial half-period in iClk cycles; legal range 1..255.
REQ-002 iClk  input  1  system clock; all logic on its rising edge.
REQ-003 iRst  input  1  reset, synchronous, active-high.
REQ-004 i250mSCE  input  1  one-cycle 250 ms clock-enable pulse that triggers a display refresh.
REQ-005 iFaultCode  input  8  fault code from the fault scanner; index of the faulted VR.
REQ-006 iFaultPresent  input  1  high when at least one fault is active.
REQ-007 iFaultStage  input  4  power stage of the fault; 15 means multiple faults.
REQ-008 oSerData  output  1  serial data to the LED shift register (595-style), MSB first.
REQ-009 oSerClk  output  1  serial shift clock.
REQ-010 oSerLatch  output  1  storage-register latch strobe.
REQ-011 oBusy  output  1  high while a frame is in flight.
REQ-012 oDisplayCode  output  8  code captured for the frame currently or last sent.

Function
REQ-013 The FSM SHALL have four states: IDLE, LOAD, SHIFT, LATCH.
- IDLE->LOAD on a refresh request.
- LOAD->SHIFT after 1 cycle.
- SHIFT->LATCH after 32*CLK_DIV cycles.
- LATCH->IDLE after CLK_DIV cycles.
REQ-014 A refresh request SHALL be an i250mSCE pulse seen in IDLE, or a pending flag set.
REQ-015 An i250mSCE pulse outside IDLE SHALL set the pending flag; further pulses SHALL NOT queue more than one request.
REQ-016 In LOAD, the block SHALL capture iFaultCode into oDisplayCode, build the 16-bit frame and clear the pending flag.
REQ-017 The frame SHALL be {segHi[7:0], segLo[7:0]}.
- Each byte is {dp,g,f,e,d,c,b,a}, active-low.
- segHi encodes iFaultCode[7:4]; segLo encodes iFaultCode[3:0].
REQ-018 The hex-to-segment table SHALL be: 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 A:88 B:83 C:C6 D:A1 E:86 F:8E.
REQ-019 When iFaultStage==15 and iFaultPresent=1 at LOAD, segHi bit7 (dp) SHALL be 0.
REQ-020 When iFaultPresent=0 at LOAD, the frame SHALL be 16'hBFBF ("--").
REQ-021 Each bit in SHIFT SHALL take 2*CLK_DIV cycles.
- oSerData presented with oSerClk low for CLK_DIV cycles.
- oSerClk then high for CLK_DIV cycles.
- oSerData changes only while oSerClk is low.
REQ-022 oSerLatch SHALL be high for all CLK_DIV cycles of LATCH; oSerClk SHALL stay low in LATCH.
REQ-023 oBusy SHALL be high in LOAD, SHIFT and LATCH, and low in IDLE.
REQ-024 Frame length SHALL be 1 + 33*CLK_DIV cycles; the refresh-to-latch-fall latency is fixed.
REQ-025 Bit and divider counters SHALL be 5 and 8 bits wide and SHALL NOT wrap within a frame.
REQ-026 A pending request SHALL start LOAD on the cycle after the LATCH->IDLE transition.
REQ-027 An i250mSCE pulse on the same cycle as LATCH->IDLE SHALL be treated as pending, giving one further frame, not two.

Reset
REQ-028 iRst high SHALL force, at the next edge, regardless of state:
- state IDLE;
- pending flag cleared;
- oSerData=0, oSerClk=0, oSerLatch=0, oBusy=0, oDisplayCode=8'h00.
REQ-029 Reset mid-frame SHALL abort the frame with no latch pulse; the first frame after reset follows the first i250mSCE.

Configuration
REQ-030 With macro FAULT_BLINK_EN defined:
- a blink phase bit toggles on every captured refresh;
- when iFaultPresent=1 and phase=1, the frame SHALL be 16'hFFFF (blank), giving a 2 Hz blink;
- the phase bit resets to 0.
REQ-031 Without FAULT_BLINK_EN, no blink phase logic SHALL exist and every frame follows REQ-017..REQ-020.

Verification
REQ-032 CLK_DIV=2; iFaultCode=8'h1A, iFaultPresent=1, iFaultStage=3; one i250mSCE.
- Shifted bits = 16'hF988; oSerLatch high 2 cycles; oBusy high 67 cycles; oDisplayCode=8'h1A.
REQ-033 iFaultCode=8'h05, iFaultStage=15, iFaultPresent=1 -> frame 16'h4092.
REQ-034 iFaultPresent=0 with any code -> frame 16'hBFBF.
REQ-035 Three i250mSCE pulses during one frame -> exactly one extra frame; second LOAD on the cycle after the first frame's LATCH->IDLE.
REQ-036 iRst asserted mid-SHIFT -> all outputs 0 next cycle, no latch pulse; a later i250mSCE sends a complete frame.
REQ-037 FAULT_BLINK_EN defined, code 8'h1A faulted, four refreshes -> frames F988, FFFF, F988, FFFF.
